// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared envelope types, register offsets and reset values
package tone_pkg;

    localparam int ENV_LEVEL_W = 8;
    localparam int ENV_ACC_W   = 16;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

    localparam logic [4:0] ENV_OFF_GATE = 5'd0;
    localparam logic [4:0] ENV_OFF_AR   = 5'd1;
    localparam logic [4:0] ENV_OFF_DR   = 5'd2;
    localparam logic [4:0] ENV_OFF_SL   = 5'd3;
    localparam logic [4:0] ENV_OFF_RR   = 5'd4;

    localparam logic [ENV_LEVEL_W-1:0] ENV_AR_RST = 8'h10;
    localparam logic [ENV_LEVEL_W-1:0] ENV_DR_RST = 8'h04;
    localparam logic [ENV_LEVEL_W-1:0] ENV_SL_RST = 8'hC0;
    localparam logic [ENV_LEVEL_W-1:0] ENV_RR_RST = 8'h08;

endpackage

// File: rtl/env_gain_mult.sv
// rtl/env_gain_mult.sv - two-stage sample x envelope-gain pipeline
module env_gain_mult
    import tone_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [SAMPLE_W-1:0]    sample_i,
    input  logic [ENV_LEVEL_W-1:0] level_i,
    input  logic                   valid_i,
    output logic [SAMPLE_W-1:0]    data_o,
    output logic                   valid_o
);

    localparam int PROD_W = SAMPLE_W + 9;

    logic [SAMPLE_W-1:0]  sample_q;
    logic [8:0]           gain_q;
    logic                 v1_q;
    logic [8:0]           gain_d;
    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] product;
    logic [SAMPLE_W-1:0]  data_q;
    logic                 v2_q;

    // Full-scale level maps to 256 so that the top level is an exact pass-through.
    assign gain_d     = (level_i == 8'hFF) ? 9'd256 : {1'b0, level_i};
    assign sample_ext = {{9{sample_q[SAMPLE_W-1]}}, sample_q};
    assign gain_ext   = {{(PROD_W-9){1'b0}}, gain_q};
    assign product    = sample_ext * gain_ext;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sample_q <= '0;
            gain_q   <= '0;
            v1_q     <= 1'b0;
            data_q   <= '0;
            v2_q     <= 1'b0;
        end else begin
            v1_q <= valid_i;
            v2_q <= v1_q;
            if (valid_i) begin
                sample_q <= sample_i;
                gain_q   <= gain_d;
            end
            if (v1_q) begin
                data_q <= product[SAMPLE_W+7:8];
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = v2_q;

endmodule

// File: rtl/envelope_shaper.sv
// rtl/envelope_shaper.sv - ADSR envelope FSM, config registers and output scaling
// Optional exponential release tail: ENVELOPE_EXP_RELEASE_EN
module envelope_shaper
    import tone_pkg::*;
#(
    parameter logic [4:0] ENV_BASE_ADDR = 5'd24,
    parameter int          SAMPLE_W     = 16
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [15:0]         data_in,
    input  logic [4:0]          addr_in,
    input  logic                data_valid_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid_in,
    output logic [SAMPLE_W-1:0] data_out,
    output logic                data_valid_out
);

    env_state_e             state_q, state_d, state_eff;
    logic [ENV_ACC_W-1:0]   acc_q, acc_d;
    logic                   gate_reg_q, gate_q;
    logic [ENV_LEVEL_W-1:0] ar_q, dr_q, sl_q, rr_q;
    logic [4:0]             reg_off;
    logic                   gate_rise, gate_fall;
    logic [ENV_ACC_W:0]     attack_sum;
    logic [ENV_ACC_W:0]     decay_limit;
    logic [ENV_ACC_W-1:0]   sl_floor;
`ifdef ENVELOPE_EXP_RELEASE_EN
    logic [ENV_ACC_W:0]     rel_step;
`endif

    // Addresses below the base wrap to large offsets and fall outside the map.
    assign reg_off   = addr_in - ENV_BASE_ADDR;
    assign gate_rise = gate_reg_q & ~gate_q;
    assign gate_fall = ~gate_reg_q & gate_q;

    assign sl_floor    = {sl_q, 8'h00};
    assign attack_sum  = {1'b0, acc_q} + {1'b0, ar_q, 8'h00};
    assign decay_limit = {1'b0, sl_floor} + {1'b0, dr_q, 8'h00};
`ifdef ENVELOPE_EXP_RELEASE_EN
    assign rel_step    = ({1'b0, acc_q} >> rr_q[3:0]) + 17'd1;
`endif

    always_comb begin
        state_eff = state_q;
        state_d   = state_q;
        acc_d     = acc_q;
        if (sample_valid_in) begin
            if (gate_rise) begin
                state_eff = ENV_ATTACK;
            end else if (gate_fall && state_q != ENV_IDLE) begin
                state_eff = ENV_RELEASE;
            end
            state_d = state_eff;
            // The step of the state entered at this tick is applied in the same tick.
            case (state_eff)
                ENV_ATTACK: begin
                    if (ar_q == 8'h00 || attack_sum >= 17'h0FFFF) begin
                        acc_d   = 16'hFFFF;
                        state_d = ENV_DECAY;
                    end else begin
                        acc_d = attack_sum[ENV_ACC_W-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (dr_q == 8'h00 || {1'b0, acc_q} <= decay_limit) begin
                        acc_d   = sl_floor;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        acc_d = acc_q - {dr_q, 8'h00};
                    end
                end
                ENV_SUSTAIN: begin
                    acc_d = sl_floor;
                end
                ENV_RELEASE: begin
`ifdef ENVELOPE_EXP_RELEASE_EN
                    if (rr_q[3:0] == 4'd0 || rel_step >= {1'b0, acc_q}) begin
                        acc_d   = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        acc_d = acc_q - rel_step[ENV_ACC_W-1:0];
                    end
`else
                    if (rr_q == 8'h00 || acc_q <= {rr_q, 8'h00}) begin
                        acc_d   = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        acc_d = acc_q - {rr_q, 8'h00};
                    end
`endif
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= ENV_IDLE;
            acc_q      <= '0;
            gate_q     <= 1'b0;
            gate_reg_q <= 1'b0;
            ar_q       <= ENV_AR_RST;
            dr_q       <= ENV_DR_RST;
            sl_q       <= ENV_SL_RST;
            rr_q       <= ENV_RR_RST;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (sample_valid_in) begin
                gate_q <= gate_reg_q;
            end
            if (data_valid_in) begin
                case (reg_off)
                    ENV_OFF_GATE: gate_reg_q <= data_in[0];
                    ENV_OFF_AR:   ar_q       <= data_in[7:0];
                    ENV_OFF_DR:   dr_q       <= data_in[7:0];
                    ENV_OFF_SL:   sl_q       <= data_in[7:0];
                    ENV_OFF_RR:   rr_q       <= data_in[7:0];
                    default: ;
                endcase
            end
        end
    end

    env_gain_mult #(
        .SAMPLE_W (SAMPLE_W)
    ) u_gain (
        .clk_i   (clk_in),
        .reset_i (reset_in),
        .sample_i(sample_in),
        .level_i (acc_d[ENV_ACC_W-1:ENV_ACC_W-ENV_LEVEL_W]),
        .valid_i (sample_valid_in),
        .data_o  (data_out),
        .valid_o (data_valid_out)
    );

endmodule

// File: tb/tb_envelope_shaper.sv
// tb/tb_envelope_shaper.sv - directed self-checking bench for envelope_shaper
module tb_envelope_shaper;

    logic        clk = 1'b0;
    logic        reset_in;
    logic [15:0] data_in;
    logic [4:0]  addr_in;
    logic        data_valid_in;
    logic [15:0] sample_in;
    logic        sample_valid_in;
    logic [15:0] data_out;
    logic        data_valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    envelope_shaper dut (
        .clk_in         (clk),
        .reset_in       (reset_in),
        .data_in        (data_in),
        .addr_in        (addr_in),
        .data_valid_in  (data_valid_in),
        .sample_in      (sample_in),
        .sample_valid_in(sample_valid_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        addr_in       = a;
        data_in       = d;
        data_valid_in = 1'b1;
        @(negedge clk);
        data_valid_in = 1'b0;
    endtask

    task automatic do_sample(input logic [15:0] s, input logic [15:0] exp, input string tag);
        @(negedge clk);
        sample_in       = s;
        sample_valid_in = 1'b1;
        @(negedge clk);
        sample_valid_in = 1'b0;
        check({tag, "_lat"}, {15'd0, data_valid_out}, 16'd0);
        @(negedge clk);
        check({tag, "_vld"}, {15'd0, data_valid_out}, 16'd1);
        check(tag, data_out, exp);
    endtask

    initial begin
        logic [15:0] e;
        logic        seen_v;
        reset_in        = 1'b1;
        data_in         = '0;
        addr_in         = '0;
        data_valid_in   = 1'b0;
        sample_in       = '0;
        sample_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_in = 1'b0;
        check("rst_data", data_out, 16'h0000);
        check("rst_vld", {15'd0, data_valid_out}, 16'd0);

        do_sample(16'h4000, 16'h0000, "idle_out");
        @(negedge clk);
        check("vld_one_cycle", {15'd0, data_valid_out}, 16'd0);

        wr(5'd25, 16'h0040);
        wr(5'd24, 16'h0001);
        do_sample(16'h7FFF, 16'h1FFF, "atk_40");
        do_sample(16'h7FFF, 16'h3FFF, "atk_80");
        do_sample(16'h7FFF, 16'h5FFF, "atk_c0");
        do_sample(16'h7FFF, 16'h7FFF, "atk_unity");

        wr(5'd26, 16'h0010);
        wr(5'd27, 16'h0080);
        for (int i = 0; i < 7; i++) begin
            do_sample(16'h0100, 16'h00EF - 16'(i * 16), "decay");
        end
        do_sample(16'h0100, 16'h0080, "sus_enter");
        do_sample(16'h0100, 16'h0080, "sus_hold");

        @(negedge clk);
        sample_in = 16'h7FFF; sample_valid_in = 1'b1;
        @(negedge clk);
        sample_in = 16'h8000;
        @(negedge clk);
        sample_valid_in = 1'b0;
        check("b2b_v0", {15'd0, data_valid_out}, 16'd1);
        check("b2b_pos", data_out, 16'h3FFF);
        @(negedge clk);
        check("b2b_v1", {15'd0, data_valid_out}, 16'd1);
        check("b2b_neg", data_out, 16'hC000);

        wr(5'd27, 16'h0060);
        do_sample(16'h0100, 16'h0060, "sl_live");
        wr(5'd27, 16'h0080);
        wr(5'd29, 16'h0000);
        wr(5'd23, 16'h0000);
        do_sample(16'h0100, 16'h0080, "bad_addr");

`ifdef ENVELOPE_EXP_RELEASE_EN
        wr(5'd28, 16'h0001);
        wr(5'd24, 16'h0000);
        e = 16'h8000;
        for (int i = 0; i < 15; i++) begin
            e = (e > (e >> 1) + 16'd1) ? e - ((e >> 1) + 16'd1) : 16'd0;
            do_sample(16'h0100, {8'h00, e[15:8]}, "rel_exp");
        end
        check("rel_exp_zero", e, 16'h0000);
`else
        wr(5'd28, 16'h0020);
        wr(5'd24, 16'h0000);
        do_sample(16'h0100, 16'h0060, "rel_60");
        do_sample(16'h0100, 16'h0040, "rel_40");
        do_sample(16'h0100, 16'h0020, "rel_20");
        do_sample(16'h0100, 16'h0000, "rel_00");
`endif
        do_sample(16'h7FFF, 16'h0000, "idle_after_rel");

        @(negedge clk);
        addr_in = 5'd24; data_in = 16'h0001; data_valid_in = 1'b1;
        sample_in = 16'h0100; sample_valid_in = 1'b1;
        @(negedge clk);
        data_valid_in = 1'b0; sample_valid_in = 1'b0;
        @(negedge clk);
        check("same_cyc_vld", {15'd0, data_valid_out}, 16'd1);
        check("same_cyc_noedge", data_out, 16'h0000);
        do_sample(16'h0100, 16'h0040, "retrig_40");
        do_sample(16'h0100, 16'h0080, "retrig_80");

        @(negedge clk);
        sample_in = 16'h0100; sample_valid_in = 1'b1;
        @(negedge clk);
        sample_valid_in = 1'b0; reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        seen_v = data_valid_out;
        check("mid_rst_data", data_out, 16'h0000);
        repeat (4) begin
            @(negedge clk);
            seen_v = seen_v | data_valid_out;
        end
        check("mid_rst_novld", {15'd0, seen_v}, 16'd0);

        wr(5'd24, 16'h0001);
        for (int i = 1; i < 16; i++) begin
            do_sample(16'h0100, 16'(i * 16), "rst_ar");
        end
        do_sample(16'h0100, 16'h0100, "rst_ar_top");
        do_sample(16'h0100, 16'h00FB, "rst_dr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
